// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared state encoding and sizing helper for the bit-serial adder
package serial_add_pkg;
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;
   function automatic int cnt_w(input int w);
      return (w > 2) ? $clog2(w) : 1;
   endfunction
endpackage

// File: rtl/serial_adder_fa_cell.sv
// fa_cell: combinational one-bit full adder
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic sum,
   output logic cout
);
   assign sum  = a ^ b ^ c;
   assign cout = (a & b) | (c & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial adder, one full-adder cell plus a carry flop,
// with a parallel registered result and a serial sum stream
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum_out,
   output logic             cout,
   output logic             ser_sum,
   output logic             ser_valid
);
   import serial_add_pkg::*;
   localparam int CW = cnt_w(WIDTH);
   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] a_sr_q, b_sr_q, sum_out_q, sum_sh;
   logic [WIDTH-2:0] sum_sr_q;
   logic [CW-1:0]    count_q;
   logic             carry_q, cout_q, fa_s, fa_c, last_step;
   fa_cell u_fa (
      .a   (a_sr_q[0]),
      .b   (b_sr_q[0]),
      .c   (carry_q),
      .sum (fa_s),
      .cout(fa_c)
   );
   // sum_sr keeps only the WIDTH-1 bits already produced; the live cell bit completes it
   assign sum_sh    = {fa_s, sum_sr_q};
   assign last_step = (state_q == S_RUN) && (count_q == CW'(WIDTH - 1));
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end
   always_comb begin
      state_d = (state_q == S_IDLE) ? (start ? S_RUN : S_IDLE) :
                (state_q == S_RUN)  ? (last_step ? S_DONE : S_RUN) : S_IDLE;
   end
   always_comb begin
      busy      = state_q != S_IDLE;
      done      = state_q == S_DONE;
      ser_valid = state_q == S_RUN;
      ser_sum   = (state_q == S_RUN) ? fa_s : 1'b0;
      sum_out   = sum_out_q;
      cout      = cout_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         a_sr_q    <= '0;
         b_sr_q    <= '0;
         sum_sr_q  <= '0;
         carry_q   <= 1'b0;
         count_q   <= '0;
         sum_out_q <= '0;
         cout_q    <= 1'b0;
      end else if (state_q == S_IDLE && start) begin
         a_sr_q  <= a_in;
         b_sr_q  <= b_in;
         carry_q <= cin;
         count_q <= '0;
      end else if (state_q == S_RUN) begin
         a_sr_q   <= a_sr_q >> 1;
         b_sr_q   <= b_sr_q >> 1;
         sum_sr_q <= sum_sh[WIDTH-1:1];
         carry_q  <= fa_c;
         count_q  <= count_q + CW'(1);
         if (last_step) begin
            sum_out_q <= sum_sh;
            cout_q    <= fa_c;
         end
      end
   end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard bench; driver pushes a+b+cin, monitor checks each done
module tb_serial_adder;
   localparam int W = 8;
   logic         clk = 1'b0, rst = 1'b1, start = 1'b0, cin = 1'b0;
   logic [W-1:0] a_in = '0, b_in = '0;
   logic         busy, done, cout, ser_sum, ser_valid;
   logic [W-1:0] sum_out;
   int           errors = 0, checks = 0;
   logic [W:0]   sb[$];
   logic [W-1:0] ser_bits = '0;
   int           nbits = 0, cyc = 0, last_done = -1, done_cnt = 0;
   bit           b2b = 1'b0;

   serial_adder #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in), .cin(cin),
      .busy(busy), .done(done), .sum_out(sum_out), .cout(cout),
      .ser_sum(ser_sum), .ser_valid(ser_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
      return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
   endfunction

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // monitor: collects the serial stream and pops the scoreboard on every done
   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         sb.delete();
         nbits = 0;
         last_done = -1;
      end else begin
         if (ser_valid) begin
            ser_bits = {ser_sum, ser_bits[W-1:1]};
            nbits++;
         end
         if (done) begin
            done_cnt++;
            if (sb.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
            else begin
               logic [W:0] e;
               e = sb.pop_front();
               chk("sum_out", 32'(sum_out), 32'(e[W-1:0]));
               chk("cout", 32'(cout), 32'(e[W]));
               chk("ser_stream", 32'(ser_bits), 32'(e[W-1:0]));
               chk("ser_count", nbits, W);
            end
            if (b2b && last_done >= 0) chk("done_spacing", cyc - last_done, 10);
            last_done = b2b ? cyc : -1;
            nbits = 0;
         end
      end
   end

   // runs one op from IDLE; optional re-pulse of start (with new operands) mid-op and in DONE
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input bit repulse);
      int n = 0, d0;
      d0 = done_cnt;
      a_in = a; b_in = b; cin = c; start = 1'b1;
      sb.push_back(ref_add(a, b, c));
      tick();
      while (busy && n < 20) begin
         n++;
         start = repulse && (n == 3 || done);
         if (repulse) begin
            a_in = W'($urandom); b_in = W'($urandom); cin = 1'($urandom);
         end
         tick();
      end
      start = 1'b0;
      chk("busy_cycles", n, 9);
      tick(); tick();
      chk("done_count", done_cnt - d0, 1);
   endtask

   initial begin
      int d0;
      tick(); tick();
      rst = 1'b0;
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_sum", 32'(sum_out), 0);
      chk("rst_cout", 32'(cout), 0);
      chk("rst_ser", {30'd0, ser_sum, ser_valid}, 0);
      tick();
      run_op(8'h5A, 8'h3C, 1'b0, 1'b0);
      chk("dir_5a_3c", {23'd0, cout, sum_out}, 32'h096);
      run_op(8'hFF, 8'h01, 1'b0, 1'b0);
      chk("dir_ff_01", {23'd0, cout, sum_out}, 32'h100);
      run_op(8'hFF, 8'hFF, 1'b1, 1'b0);
      chk("dir_ff_ff_1", {23'd0, cout, sum_out}, 32'h1FF);
      run_op(8'h5A, 8'h3C, 1'b1, 1'b1);
      chk("repulse_result", {23'd0, cout, sum_out}, 32'h097);
      // abort at bit-step 4
      d0 = done_cnt;
      a_in = 8'h5A; b_in = 8'h3C; cin = 1'b0; start = 1'b1;
      sb.push_back(ref_add(8'h5A, 8'h3C, 1'b0));
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_busy", 32'(busy), 0);
      chk("abort_sum", 32'(sum_out), 0);
      chk("abort_cout", 32'(cout), 0);
      repeat (12) tick();
      chk("abort_no_done", done_cnt - d0, 0);
      run_op(8'h01, 8'h02, 1'b0, 1'b0);
      chk("after_abort", {23'd0, cout, sum_out}, 32'h003);
      // rst wins over start
      rst = 1'b1; start = 1'b1;
      tick();
      rst = 1'b0; start = 1'b0;
      chk("rst_start_busy", 32'(busy), 0);
      tick();
      chk("rst_start_busy2", 32'(busy), 0);
      // back-to-back with start held high
      b2b = 1'b1;
      start = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         logic [W-1:0] a, b;
         logic c;
         a = W'($urandom); b = W'($urandom); c = 1'($urandom);
         if (i < 2) begin a = (i == 0) ? 8'h00 : 8'hFF; b = a; c = 1'b1; end
         a_in = a; b_in = b; cin = c;
         sb.push_back(ref_add(a, b, c));
         tick();
         for (int k = 0; k < 9; k++) begin
            a_in = W'($urandom); b_in = W'($urandom); cin = 1'($urandom);
            tick();
         end
      end
      start = 1'b0;
      repeat (12) tick();
      b2b = 1'b0;
      chk("b2b_idle", 32'(busy), 0);
      chk("sb_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
